// File: rtl/cfg_mux_bank.sv
// Bank of routing multiplexers whose selects come from a double-buffered configuration
// register: frames stream into a shadow copy, and a commit swaps the whole bank at once.
module cfg_mux_bank #(
  parameter  int NUM_MUX    = 4,
  parameter  int MUX_INPUTS = 16,
  parameter  int FRAME_W    = 32,
  parameter  int OUT_REG    = 0,
  localparam int SEL_W      = $clog2(MUX_INPUTS),
  localparam int CFG_BITS   = NUM_MUX * SEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MUX*MUX_INPUTS-1:0] mux_in,
  output logic [NUM_MUX-1:0]            mux_out,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [FRAME_W-1:0]            cfg_data,
  input  logic                          cfg_last,
  input  logic                          commit,
  input  logic                          abort,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic [CFG_BITS-1:0]           active_sel
);

  // state    | meaning
  // ST_LOAD  | accepting frame words into the shadow register
  // ST_ARMED | complete frame held in shadow, waiting for commit

  localparam int NWORDS = (CFG_BITS + FRAME_W - 1) / FRAME_W;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SH_W   = NWORDS * FRAME_W;

  typedef enum logic {ST_LOAD, ST_ARMED} state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] word_data, word_mask;
  logic                transfer, last_word;
  logic                shadow_we, commit_go, err_set;
  logic [NUM_MUX-1:0]  mux_comb;

  assign cfg_ready = (state == ST_LOAD) && !rst;
  assign transfer  = cfg_valid && cfg_ready;
  assign last_word = (wcnt == WCNT_W'(NWORDS - 1));

  // Word placement is done on a word-padded vector, then truncated so padding bits vanish.
  assign word_data = CFG_BITS'(SH_W'(cfg_data) << (int'(wcnt) * FRAME_W));
  assign word_mask = CFG_BITS'(SH_W'({FRAME_W{1'b1}}) << (int'(wcnt) * FRAME_W));

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    shadow_we = 1'b0;
    commit_go = 1'b0;
    err_set   = 1'b0;
    if (abort) begin
      state_nxt = ST_LOAD;
      wcnt_nxt  = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (transfer) begin
            shadow_we = 1'b1;
            if (cfg_last != last_word) begin
              err_set  = 1'b1;
              wcnt_nxt = '0;
            end else if (cfg_last) begin
              state_nxt = ST_ARMED;
              wcnt_nxt  = '0;
            end else begin
              wcnt_nxt = wcnt + WCNT_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (commit) begin
            commit_go = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
        default: begin
          state_nxt = ST_LOAD;
          wcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      wcnt       <= '0;
      shadow     <= '0;
      active_sel <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      cfg_done <= commit_go;
      if (shadow_we)
        shadow <= (shadow & ~word_mask) | word_data;
      if (commit_go)
        active_sel <= shadow;
      if (commit_go)
        cfg_err <= 1'b0;
      else if (err_set)
        cfg_err <= 1'b1;
    end
  end

  for (genvar m = 0; m < NUM_MUX; m++) begin : g_mux
    logic [MUX_INPUTS-1:0] grp;
    logic [SEL_W-1:0]      sel;
    assign grp         = mux_in[m*MUX_INPUTS +: MUX_INPUTS];
    assign sel         = active_sel[m*SEL_W +: SEL_W];
    assign mux_comb[m] = grp[sel];
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [NUM_MUX-1:0] mux_q;
    always_ff @(posedge clk) begin
      if (rst)
        mux_q <= '0;
      else
        mux_q <= mux_comb;
    end
    assign mux_out = mux_q;
  end else begin : g_out_comb
    assign mux_out = mux_comb;
  end

endmodule

// File: tb/tb_cfg_mux_bank.sv
// Lockstep bench for cfg_mux_bank: combinational and registered-output instances share
// stimulus and are checked every cycle against a frame-level reference model.
module tb_cfg_mux_bank;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_last, commit, abort;
  logic [7:0]  cfg_data;
  logic [63:0] mux_in;
  logic [3:0]  mux_out0, mux_out1;
  logic        ready0, ready1, done0, done1, err0, err1;
  logic [15:0] act0, act1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_rst;
  bit          m_armed;
  int          m_words;
  logic [7:0]  m_shadow [2];
  logic [15:0] m_active;
  bit          m_err, m_done;
  logic [3:0]  m_out1;

  always #5 clk = ~clk;

  cfg_mux_bank #(.NUM_MUX(4), .MUX_INPUTS(16), .FRAME_W(8), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .mux_in(mux_in), .mux_out(mux_out0),
    .cfg_valid(cfg_valid), .cfg_ready(ready0), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .commit(commit), .abort(abort), .cfg_done(done0), .cfg_err(err0), .active_sel(act0)
  );

  cfg_mux_bank #(.NUM_MUX(4), .MUX_INPUTS(16), .FRAME_W(8), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .mux_in(mux_in), .mux_out(mux_out1),
    .cfg_valid(cfg_valid), .cfg_ready(ready1), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .commit(commit), .abort(abort), .cfg_done(done1), .cfg_err(err1), .active_sel(act1)
  );

  function automatic logic [3:0] route(input logic [63:0] mi, input logic [15:0] sel);
    logic [3:0] r;
    for (int m = 0; m < 4; m++)
      r[m] = mi[m*16 + int'(sel[m*4 +: 4])];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("ready0", 32'(ready0), 32'(!m_rst && !m_armed));
    check_eq("ready1", 32'(ready1), 32'(!m_rst && !m_armed));
    check_eq("active0", 32'(act0), 32'(m_active));
    check_eq("active1", 32'(act1), 32'(m_active));
    check_eq("done0", 32'(done0), 32'(m_done));
    check_eq("done1", 32'(done1), 32'(m_done));
    check_eq("err0", 32'(err0), 32'(m_err));
    check_eq("err1", 32'(err1), 32'(m_err));
    check_eq("mux_out_comb", 32'(mux_out0), 32'(route(mux_in, m_active)));
    check_eq("mux_out_reg", 32'(mux_out1), 32'(m_out1));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check at negedge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit l,
                       input bit c, input bit a, input logic [63:0] mi);
    rst = r; cfg_valid = v; cfg_data = d; cfg_last = l; commit = c; abort = a; mux_in = mi;
    m_rst = r;
    if (r) begin
      m_armed = 0; m_words = 0; m_shadow[0] = '0; m_shadow[1] = '0;
      m_active = '0; m_err = 0; m_done = 0; m_out1 = '0;
    end else begin
      m_out1 = route(mi, m_active);
      m_done = 0;
      if (a) begin
        m_words = 0;
        m_armed = 0;
      end else if (m_armed) begin
        if (c) begin
          m_active = {m_shadow[1], m_shadow[0]};
          m_done   = 1;
          m_err    = 0;
          m_armed  = 0;
        end
      end else if (v) begin
        m_shadow[m_words] = d;
        if (l != (m_words == 1)) begin
          m_err   = 1;
          m_words = 0;
        end else if (l) begin
          m_armed = 1;
          m_words = 0;
        end else begin
          m_words = m_words + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 8'h00, 0, 0, 0, 64'h1);
    check_eq("rst_mux_out", 32'(mux_out0), 32'h1);
    check_eq("rst_active", 32'(act0), 32'h0);

    // load and commit
    cycle(0, 1, 8'h21, 0, 0, 0, rnd64());
    cycle(0, 1, 8'h43, 1, 0, 0, rnd64());
    cycle(0, 0, 8'h00, 0, 1, 0, rnd64());
    check_eq("commit_sel", 32'(act0), 32'h4321);
    cycle(0, 0, 8'h00, 0, 0, 0, rnd64());

    // early last then a valid frame clears the error
    cycle(0, 1, 8'hFF, 1, 0, 0, rnd64());
    check_eq("early_err", 32'(err0), 32'h1);
    cycle(0, 0, 8'h00, 0, 1, 0, rnd64());
    check_eq("early_sel", 32'(act0), 32'h4321);
    cycle(0, 1, 8'h10, 0, 0, 0, rnd64());
    cycle(0, 1, 8'h32, 1, 0, 0, rnd64());
    cycle(0, 0, 8'h00, 0, 1, 0, rnd64());
    check_eq("err_clear", 32'(err0), 32'h0);

    // abort beats commit
    cycle(0, 1, 8'h55, 0, 0, 0, rnd64());
    cycle(0, 1, 8'h66, 1, 0, 0, rnd64());
    cycle(0, 0, 8'h00, 0, 1, 1, rnd64());
    cycle(0, 0, 8'h00, 0, 1, 0, rnd64());
    check_eq("abort_sel", 32'(act0), 32'h3210);

    // backpressure while armed
    cycle(0, 1, 8'h07, 0, 0, 0, rnd64());
    cycle(0, 1, 8'h08, 1, 0, 0, rnd64());
    for (int i = 0; i < 5; i++)
      cycle(0, 1, 8'h9A, 0, 0, 0, rnd64());
    cycle(0, 1, 8'h9A, 0, 1, 0, rnd64());
    check_eq("bp_commit_sel", 32'(act0), 32'h0807);
    cycle(0, 1, 8'h9A, 0, 0, 0, rnd64());
    cycle(0, 1, 8'hBC, 1, 0, 0, rnd64());
    cycle(0, 0, 8'h00, 0, 1, 0, rnd64());
    check_eq("bp_sel", 32'(act0), 32'hBC9A);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, l, c, a;
      r = ($urandom_range(199) == 0);
      v = ($urandom_range(9) < 7);
      l = (m_words == 1);
      if ($urandom_range(9) == 0) l = !l;
      c = ($urandom_range(3) == 0);
      a = ($urandom_range(29) == 0);
      cycle(r, v, 8'($urandom), l, c, a, rnd64());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
